// File: rtl/serial_frame_driver_if.sv
// Handshake and serial-output bundle between a word source and the
// serial frame driver. The source drives the word, its bit order and the
// abort. The driver answers with ready and the framed bit stream.
interface serial_frame_driver_if #(
  parameter int N = 64
);
  logic [N-1:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic         msb_first;
  logic         abort;
  logic         serial_out;
  logic         frame;
  logic         done;

  // Word source side
  modport master (
    output data_in, in_valid, msb_first, abort,
    input  in_ready, serial_out, frame, done
  );

  // Driver side
  modport slave (
    input  data_in, in_valid, msb_first, abort,
    output in_ready, serial_out, frame, done
  );
endinterface

// File: rtl/serial_frame_driver.sv
// Parallel-to-serial frame driver feeding the toggle-counting stage.
// It takes one N-bit word through a valid/ready handshake and shifts it out
// one bit per clock, with frame high for the N data cycles. A one-cycle done
// pulse follows the last bit, and then an optional idle gap. An abort drops
// the frame in flight without a done. Every output comes straight from a
// flop, so the counter downstream never sees a combinational glitch.
module serial_frame_driver #(
  parameter int   N        = 64,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  serial_frame_driver_if.slave    bus
);

  localparam int CW = $clog2(N);
  // A gap of zero still needs a legal vector width. The counter is then unused.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t         state_q;
  logic [N-1:0]   shreg_q;
  logic           msb_q;
  logic [CW-1:0]  bitcnt_q;
  logic [GW-1:0]  gapcnt_q;
  logic           rdy_q;
  logic           frame_q;
  logic           done_q;
  logic           sout_q;

  logic           load_bit_d;
  logic [N-1:0]   load_sh_d;
  logic           next_bit_d;
  logic [N-1:0]   next_sh_d;
  logic           last_bit;

  // Shift datapath. The first bit goes straight to the output flop at accept.
  // The register keeps only the bits still to go, already aligned so the next
  // bit always sits at the end selected by the captured order.
  always_comb begin
    load_bit_d = bus.msb_first ? bus.data_in[N-1] : bus.data_in[0];
    load_sh_d  = bus.msb_first ? (bus.data_in << 1) : (bus.data_in >> 1);
    next_bit_d = msb_q ? shreg_q[N-1] : shreg_q[0];
    next_sh_d  = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
  end

  // The bit counter stops at N-1. That count marks the cycle showing the last bit.
  assign last_bit = (bitcnt_q == CW'(N - 1));

  // Frame FSM. State and all outputs are updated together on the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      msb_q    <= 1'b0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      rdy_q    <= 1'b1;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
      sout_q   <= IDLE_LVL;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // An abort blocks the accept, so a word offered with abort is dropped.
          if (!bus.abort && bus.in_valid && rdy_q) begin
            state_q  <= S_SHIFT;
            shreg_q  <= load_sh_d;
            msb_q    <= bus.msb_first;
            bitcnt_q <= '0;
            rdy_q    <= 1'b0;
            frame_q  <= 1'b1;
            sout_q   <= load_bit_d;
          end
        end
        S_SHIFT: begin
          if (bus.abort) begin
            // Drop the frame silently and skip the gap.
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            frame_q <= 1'b0;
            sout_q  <= IDLE_LVL;
          end else if (last_bit) begin
            frame_q <= 1'b0;
            done_q  <= 1'b1;
            sout_q  <= IDLE_LVL;
            if (GAP == 0) begin
              // With no gap the driver can accept again in the done cycle.
              state_q <= S_IDLE;
              rdy_q   <= 1'b1;
            end else begin
              // The done cycle counts as the first gap cycle.
              state_q  <= S_GAP;
              gapcnt_q <= GW'(1);
            end
          end else begin
            shreg_q  <= next_sh_d;
            sout_q   <= next_bit_d;
            bitcnt_q <= bitcnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (bus.abort || (gapcnt_q == GW'(GAP))) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
          end else begin
            gapcnt_q <= gapcnt_q + GW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
          frame_q <= 1'b0;
          sout_q  <= IDLE_LVL;
        end
      endcase
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.frame      = frame_q;
  assign bus.done       = done_q;
  assign bus.serial_out = sout_q;

  // The counter relies on done never overlapping the data window.
  a_done_frame_excl : assert property (@(posedge clock) disable iff (!reset)
    !(done_q && frame_q));

endmodule

// File: tb/tb_serial_frame_driver.sv
// Bench for serial_frame_driver. It runs three instances side by side:
// N=8/GAP=2, N=64/GAP=0 and N=8/GAP=1. A timestamp model predicts every
// output on every cycle. For each accepted word it records the accept cycle,
// and the expected outputs follow from how many cycles have passed since then.
module tb_serial_frame_driver;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] din [NI];
  logic        vld [NI];
  logic        msb [NI];
  logic        abt [NI];
  logic        rdy [NI];
  logic        frm [NI];
  logic        dn  [NI];
  logic        so  [NI];

  function automatic int nn(int i); return (i == 1) ? 64 : 8; endfunction
  function automatic int gg(int i); return (i == 0) ? 2 : (i == 1) ? 0 : 1; endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N   = (g == 1) ? 64 : 8;
    localparam int GAP = (g == 0) ? 2 : (g == 1) ? 0 : 1;
    serial_frame_driver_if #(.N(N)) bus ();
    assign bus.data_in   = din[g][N-1:0];
    assign bus.in_valid  = vld[g];
    assign bus.msb_first = msb[g];
    assign bus.abort     = abt[g];
    assign rdy[g] = bus.in_ready;
    assign frm[g] = bus.frame;
    assign dn[g]  = bus.done;
    assign so[g]  = bus.serial_out;
    serial_frame_driver #(.N(N), .GAP(GAP), .IDLE_LVL(1'b0)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
    );
  end

  // Model state: the word in flight and the cycle its first bit appears.
  bit          busy [NI];
  int          acc  [NI];
  logic [63:0] word [NI];
  logic        mf   [NI];
  int          cyc;

  // Observed-stream bookkeeping, used for the literal pins.
  logic [63:0] cap      [NI];
  int          fcnt     [NI];
  int          tog      [NI];
  int          nfr      [NI];
  int          idle_run [NI];
  int          last_gap [NI];
  logic        pfrm     [NI];
  logic        pso      [NI];

  int passes = 0;
  int total  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected outputs for the current cycle from the time since the accept.
  function automatic void expect_out(int i, output logic r, output logic f,
                                     output logic d, output logic s);
    int n = nn(i);
    int g = gg(i);
    int k;
    r = 1'b1; f = 1'b0; d = 1'b0; s = 1'b0;
    if (busy[i]) begin
      k = cyc - acc[i];
      if (k < n) begin
        r = 1'b0; f = 1'b1;
        s = mf[i] ? word[i][n-1-k] : word[i][k];
      end else if (k == n) begin
        d = 1'b1; r = (g == 0);
      end else if (k < n + g) begin
        r = 1'b0;
      end
    end
  endfunction

  task automatic model_edge();
    logic r, f, d, s;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) busy[i] = 1'b0;
      else begin
        expect_out(i, r, f, d, s);
        if (abt[i]) busy[i] = 1'b0;
        else if (vld[i] && r) begin
          busy[i] = 1'b1; acc[i] = cyc + 1; word[i] = din[i]; mf[i] = msb[i];
        end
      end
    end
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) busy[i] = 1'b0;
  endtask

  task automatic compare_all();
    logic r, f, d, s;
    for (int i = 0; i < NI; i++) begin
      expect_out(i, r, f, d, s);
      chk($sformatf("i%0d_in_ready c%0d", i, cyc), 64'(rdy[i]), 64'(r));
      chk($sformatf("i%0d_frame c%0d", i, cyc), 64'(frm[i]), 64'(f));
      chk($sformatf("i%0d_done c%0d", i, cyc), 64'(dn[i]), 64'(d));
      chk($sformatf("i%0d_serial c%0d", i, cyc), 64'(so[i]), 64'(s));
      if (frm[i] && !pfrm[i]) begin
        cap[i] = '0; fcnt[i] = 0; tog[i] = 0; nfr[i]++; last_gap[i] = idle_run[i];
      end
      if (frm[i]) begin
        cap[i] = {cap[i][62:0], so[i]};
        fcnt[i]++;
        if (pfrm[i] && (so[i] != pso[i])) tog[i]++;
        idle_run[i] = 0;
      end else idle_run[i]++;
      pfrm[i] = frm[i];
      pso[i]  = so[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(int i, logic [63:0] w, logic m);
    din[i] = w; msb[i] = m; vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int lim);
    int n = 0;
    while (!dn[i] && n < lim) begin tick(); n++; end
    chk($sformatf("i%0d_done_seen", i), 64'(dn[i]), 64'd1);
  endtask

  initial begin
    int n;
    int f0;
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      din[i] = '0; vld[i] = 1'b0; msb[i] = 1'b0; abt[i] = 1'b0;
      busy[i] = 1'b0; acc[i] = 0; word[i] = '0; mf[i] = 1'b0;
      cap[i] = '0; fcnt[i] = 0; tog[i] = 0; nfr[i] = 0; idle_run[i] = 0;
      last_gap[i] = 0; pfrm[i] = 1'b0; pso[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_in_ready", 64'(rdy[0]), 64'd1);
    chk("reset_frame", 64'(frm[0]), 64'd0);
    chk("reset_serial", 64'(so[0]), 64'd0);
    rst_n = 1'b1;
    tick();

    // C1 MSB-first on the GAP=2 instance, LSB-first on the GAP=1 instance.
    // Back-to-back AAAA frames run on the 64-bit instance.
    din[1] = 64'hAAAA_AAAA_AAAA_AAAA; msb[1] = 1'b1; vld[1] = 1'b1;
    din[2] = 64'hC1; msb[2] = 1'b0; vld[2] = 1'b1;
    send(0, 64'hC1, 1'b1);
    vld[2] = 1'b0;
    chk("latency_frame", 64'(frm[0]), 64'd1);
    chk("latency_first_bit", 64'(so[0]), 64'd1);
    wait_done(0, 20);
    chk("c1_msb_stream", cap[0] & 64'hFF, 64'hC1);
    chk("c1_msb_len", 64'(fcnt[0]), 64'd8);
    chk("c1_lsb_stream", cap[2] & 64'hFF, 64'h83);
    chk("c1_lsb_len", 64'(fcnt[2]), 64'd8);
    n = 0;
    while (!rdy[0] && n < 10) begin tick(); n++; end
    chk("gap2_ready_latency", 64'(n), 64'd2);

    n = 0;
    while (nfr[1] < 2 && n < 300) begin tick(); n++; end
    chk("b2b_gap_len", 64'(last_gap[1]), 64'd1);
    wait_done(1, 80);
    chk("b2b_toggles", 64'(tog[1]), 64'd63);
    chk("b2b_len", 64'(fcnt[1]), 64'd64);

    // Abort at bit 3, then a normal frame.
    send(0, 64'h5A, 1'b1);
    repeat (3) tick();
    abt[0] = 1'b1;
    tick();
    abt[0] = 1'b0;
    chk("abort_frame", 64'(frm[0]), 64'd0);
    chk("abort_done", 64'(dn[0]), 64'd0);
    chk("abort_serial", 64'(so[0]), 64'd0);
    chk("abort_ready", 64'(rdy[0]), 64'd1);
    send(0, 64'h3C, 1'b1);
    wait_done(0, 20);
    chk("post_abort_stream", cap[0] & 64'hFF, 64'h3C);

    // An abort in the done cycle cuts the gap short.
    abt[0] = 1'b1;
    tick();
    abt[0] = 1'b0;
    chk("gap_abort_ready", 64'(rdy[0]), 64'd1);

    // In IDLE, abort wins over a valid word.
    din[2] = 64'hFF; vld[2] = 1'b1; abt[2] = 1'b1;
    tick();
    vld[2] = 1'b0; abt[2] = 1'b0;
    chk("abort_blocks_accept", 64'(frm[2]), 64'd0);

    // A valid word offered mid-frame is ignored.
    send(0, 64'h00, 1'b1);
    tick(); tick();
    din[0] = 64'hFF; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    f0 = nfr[0];
    wait_done(0, 20);
    chk("ignored_word_stream", cap[0] & 64'hFF, 64'h00);
    repeat (6) tick();
    chk("no_second_frame", 64'(nfr[0]), 64'(f0));

    // Reset asserted between edges mid-frame.
    send(0, 64'hF0, 1'b1);
    tick(); tick();
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_frame", 64'(frm[0]), 64'd0);
    chk("async_rst_serial", 64'(so[0]), 64'd0);
    chk("async_rst_done", 64'(dn[0]), 64'd0);
    chk("async_rst_ready", 64'(rdy[0]), 64'd1);
    @(negedge clk);
    compare_all();
    tick();
    rst_n = 1'b1;
    tick();
    send(0, 64'h96, 1'b1);
    wait_done(0, 20);
    chk("post_reset_stream", cap[0] & 64'hFF, 64'h96);

    // Random traffic on all instances, checked against the model each cycle.
    repeat (600) begin
      for (int i = 0; i < NI; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        din[i] = {$urandom, $urandom};
        msb[i] = 1'($urandom_range(0, 1));
        abt[i] = ($urandom_range(0, 40) == 0);
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; abt[i] = 1'b0;
    end
    repeat (80) tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
